serial_fifo_ctrl: RTL and testbench



---
 rtl/serial_fifo_ctrl.sv | 90 +++++++++
 tb/tb_serial_fifo_ctrl.sv | 118 +++++++++++
 2 files changed

// File: rtl/serial_fifo_ctrl.sv
// serial_fifo_ctrl: synchronous FIFO with occupancy flags, overwrite-oldest mode and sticky errors
module serial_fifo_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 8,
   parameter int AF_LEVEL   = DEPTH - 1,
   parameter int AE_LEVEL   = 1,
   localparam int PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW        = $clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  n_rst,
   input  logic                  clear,
   input  logic                  overwrite_en,
   input  logic                  wEnable,
   input  logic [DATA_WIDTH-1:0] wData,
   input  logic                  rEnable,
   output logic [DATA_WIDTH-1:0] rData,
   output logic [CW-1:0]         count,
   output logic                  fifoEmpty,
   output logic                  fifoFull,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic                  overflow,
   output logic                  underflow,
   input  logic                  clr_err
);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]         rptr_q, rptr_d, wptr_q, wptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic                  ovf_q, ovf_d, udf_q, udf_d;
   logic                  full, empty, pop, push, ovw, store;

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full  = count_q == CW'(DEPTH);
   assign empty = count_q == '0;
   // a read on empty is ignored; a write on full needs a same-cycle pop or overwrite mode
   assign pop   = rEnable & ~empty;
   assign push  = wEnable & (~full | pop);
   assign ovw   = wEnable & full & ~rEnable & overwrite_en;
   assign store = ~clear & (push | ovw);

   // next-state for pointers, occupancy and sticky errors; clear has priority
   always_comb begin
      rptr_d  = clear ? '0 : ((pop | ovw) ? nxt(rptr_q) : rptr_q);
      wptr_d  = clear ? '0 : ((push | ovw) ? nxt(wptr_q) : wptr_q);
      count_d = clear ? '0 : count_q + CW'(push) - CW'(pop);
      ovf_d   = clear ? 1'b0 : (ovf_q & ~clr_err) | (wEnable & full & ~rEnable);
      udf_d   = clear ? 1'b0 : (udf_q & ~clr_err) | (rEnable & empty);
   end

   // control state registers
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         rptr_q  <= '0;
         wptr_q  <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         udf_q   <= 1'b0;
      end else begin
         rptr_q  <= rptr_d;
         wptr_q  <= wptr_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         udf_q   <= udf_d;
      end
   end

   // storage array; clear leaves contents untouched
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (store) begin
         mem_q[wptr_q] <= wData;
      end
   end

   assign rData        = mem_q[rptr_q];
   assign count        = count_q;
   assign fifoEmpty    = empty;
   assign fifoFull     = full;
   assign almost_full  = count_q >= CW'(AF_LEVEL);
   assign almost_empty = count_q <= CW'(AE_LEVEL);
   assign overflow     = ovf_q;
   assign underflow    = udf_q;

endmodule

// File: tb/tb_serial_fifo_ctrl.sv
// tb_serial_fifo_ctrl: directed and random checks against a queue-based FIFO model
module tb_serial_fifo_ctrl;

   logic       clk = 1'b0;
   logic       n_rst = 1'b0;
   logic       clear = 1'b0, overwrite_en = 1'b0, wEnable = 1'b0, rEnable = 1'b0, clr_err = 1'b0;
   logic [7:0] wData = '0, rData;
   logic [2:0] count;
   logic       fifoEmpty, fifoFull, almost_full, almost_empty, overflow, underflow;

   int n_chk = 0, n_pass = 0;
   logic [7:0] q[$];
   logic m_ovf = 1'b0, m_udf = 1'b0;
   logic [7:0] d;

   serial_fifo_ctrl #(.DATA_WIDTH(8), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1)) dut (
      .clk(clk), .n_rst(n_rst), .clear(clear), .overwrite_en(overwrite_en),
      .wEnable(wEnable), .wData(wData), .rEnable(rEnable), .rData(rData),
      .count(count), .fifoEmpty(fifoEmpty), .fifoFull(fifoFull),
      .almost_full(almost_full), .almost_empty(almost_empty),
      .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic chk_all(input bit rd);
      int n = q.size();
      chk("count", 32'(count), 32'(n));
      chk("flags", {fifoEmpty, fifoFull, almost_full, almost_empty, overflow, underflow},
          {n == 0, n == 4, n >= 3, n <= 1, m_ovf, m_udf});
      if (rd && n > 0) chk("rdata", 32'(rData), 32'(q[0]));
   endtask

   task automatic step(input bit w, input logic [7:0] wd, input bit r,
                       input bit ow = 0, input bit clr = 0, input bit ce = 0);
      bit full, empty;
      wEnable = w; wData = wd; rEnable = r; overwrite_en = ow; clear = clr; clr_err = ce;
      @(posedge clk);
      #1;
      wEnable = 0; rEnable = 0; clear = 0; clr_err = 0;
      if (clr) begin
         q.delete(); m_ovf = 0; m_udf = 0;
      end else begin
         full = q.size() == 4;
         empty = q.size() == 0;
         if (r && !empty) void'(q.pop_front());
         if (w) begin
            if (q.size() < 4) q.push_back(wd);
            else if (ow) begin void'(q.pop_front()); q.push_back(wd); end
         end
         m_ovf = (m_ovf && !ce) || (w && full && !r);
         m_udf = (m_udf && !ce) || (r && empty);
      end
      chk_all(1);
   endtask

   task automatic do_reset();
      n_rst = 0;
      #1;
      q.delete(); m_ovf = 0; m_udf = 0;
      chk_all(0);
      chk("rst_rdata", 32'(rData), 32'h0);
      @(posedge clk); #2;
      n_rst = 1;
      #1;
   endtask

   initial begin
      #1;
      do_reset();
      for (int i = 0; i < 4; i++) step(1, 8'hA1 + 8'(i), 0);
      for (int i = 0; i < 4; i++) begin
         chk("drain", 32'(rData), 32'(8'hA1 + 8'(i)));
         step(0, 0, 1);
      end
      for (int i = 0; i < 10; i++) begin
         step(1, 8'(i), 0);
         chk("wrap", 32'(rData), 32'(i));
         step(0, 0, 1);
      end
      for (int ow = 0; ow < 2; ow++) begin
         for (int i = 0; i < 4; i++) step(1, 8'h10 + 8'(i), 0);
         step(1, 8'h14, 0, 1'(ow));
         chk("ovf", 32'(overflow), 32'h1);
         for (int i = 0; i < 4; i++) begin
            chk("ovf_rd", 32'(rData), 32'(8'h10 + 8'(i + ow)));
            step(0, 0, 1);
         end
         step(0, 0, 0, 0, 0, 1);
      end
      step(0, 0, 1);
      chk("udf", 32'(underflow), 32'h1);
      step(0, 0, 0, 0, 0, 1);
      chk("udf_clr", 32'(underflow), 32'h0);
      step(1, 8'h55, 0);
      step(1, 8'h66, 0);
      step(0, 0, 0, 0, 1);
      chk("clear_empty", 32'(fifoEmpty), 32'h1);
      step(1, 8'h77, 0);
      step(1, 8'h88, 0);
      #3;
      do_reset();
      for (int i = 0; i < 400; i++) begin
         d = 8'($urandom);
         step(1'($urandom_range(0, 99) < 55), d, 1'($urandom_range(0, 99) < 45),
              1'($urandom), 1'($urandom_range(0, 99) < 3), 1'($urandom_range(0, 99) < 10));
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
